// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-buffer types, count states and default field widths
package pipe_pkg;

    // Occupancy of a 2-entry skid buffer.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } cnt_e;

    // Default field widths shared by the IF/ID, ID/EX and EX/MEM buffers.
    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 12;
    localparam int GO_N_DEF    = 2;

    // Instruction presented when a stage holds no valid entry (NOP).
    localparam logic [31:0] BUBBLE_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - payload register with load enable and synchronous clear-to-constant
// Ports: clk, rst_n (async active-low, resets to CLR_VAL), load (capture d),
//        clr (sync clear to CLR_VAL, wins over load), d (payload in), q (payload out).
module pipe_entry_reg #(
    parameter int           W       = 56,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_buf.sv
// rtl/if_id_skid_buf.sv - IF->ID pipeline buffer with valid/ready handshake and 2-entry skid
// Ports: clk, rst_n (async active-low), go[GO_N] (all must be 1 to advance), flush (sync clear),
//        in_valid/in_ready/in_pc_4/in_instr/in_addr (fetch side),
//        out_valid/out_ready/out_pc_4/out_instr/out_addr (decode side).
// Optional macro IF_ID_SKID_PERF_EN adds perf_stall_cnt and perf_flush_cnt (16-bit, saturating).
module if_id_skid_buf
    import pipe_pkg::*;
#(
    parameter int                 PC_W         = PC_W_DEF,
    parameter int                 INSTR_W      = INSTR_W_DEF,
    parameter int                 ADDR_W       = ADDR_W_DEF,
    parameter int                 GO_N         = GO_N_DEF,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(BUBBLE_INSTR_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [GO_N-1:0]    go,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc_4,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc_4,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr
`ifdef IF_ID_SKID_PERF_EN
    ,
    output logic [15:0]        perf_stall_cnt,
    output logic [15:0]        perf_flush_cnt
`endif
);

    localparam int                 ENTRY_W   = PC_W + INSTR_W + ADDR_W;
    localparam logic [ENTRY_W-1:0] ENTRY_CLR = {{PC_W{1'b0}}, BUBBLE_INSTR, {ADDR_W{1'b0}}};

    cnt_e               count_q;
    cnt_e               count_nxt;
    logic               go_all;
    logic               in_fire;
    logic               out_fire;
    logic               head_load;
    logic               head_clr;
    logic               head_from_skid;
    logic               skid_load;
    logic               skid_clr;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] head_d;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] skid_q;

    assign go_all = &go;

    // in_ready looks only at registered occupancy, go and flush, so the
    // decode-side ready never reaches the fetch side combinationally.
    // rst_n is included so in_ready is low throughout reset.
    assign in_ready  = rst_n & go_all & (count_q != CNT_FULL) & ~flush;
    assign out_valid = go_all & (count_q != CNT_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign in_entry = {in_pc_4, in_instr, in_addr};
    assign head_d   = head_from_skid ? skid_q : in_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_EMPTY;
        end else begin
            count_q <= count_nxt;
        end
    end

    always_comb begin
        count_nxt      = count_q;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            count_nxt = CNT_EMPTY;
            head_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (in_fire) begin
                        count_nxt = CNT_ONE;
                        head_load = 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (in_fire && !out_fire) begin
                        count_nxt = CNT_FULL;
                        skid_load = 1'b1;
                    end else if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (out_fire) begin
                        // Clear head on draining so an empty stage shows the bubble.
                        count_nxt = CNT_EMPTY;
                        head_clr  = 1'b1;
                    end
                end
                CNT_FULL: begin
                    if (out_fire) begin
                        count_nxt      = CNT_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: begin
                    count_nxt = CNT_EMPTY;
                    head_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end
    end

    pipe_entry_reg #(
        .W       (ENTRY_W),
        .CLR_VAL (ENTRY_CLR)
    ) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .clr   (head_clr),
        .d     (head_d),
        .q     (head_q)
    );

    pipe_entry_reg #(
        .W       (ENTRY_W),
        .CLR_VAL (ENTRY_CLR)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_entry),
        .q     (skid_q)
    );

    assign {out_pc_4, out_instr, out_addr} = head_q;

`ifdef IF_ID_SKID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 16'h0000;
            perf_flush_cnt <= 16'h0000;
        end else begin
            if (in_valid && !in_ready && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'h0001;
            end
            if (flush && perf_flush_cnt != 16'hFFFF) begin
                perf_flush_cnt <= perf_flush_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_buf.sv
// tb/tb_if_id_skid_buf.sv - self-checking directed bench for if_id_skid_buf
module tb_if_id_skid_buf;

    logic        clk;
    logic        rst_n;
    logic [1:0]  go;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_pc_4;
    logic [31:0] in_instr;
    logic [11:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pc_4;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
`ifdef IF_ID_SKID_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [1:0]  go;
        logic        flush;
        logic        in_valid;
        logic [11:0] pc_4;
        logic [31:0] instr;
        logic [11:0] addr;
        logic        out_ready;
        logic        e_in_ready;
        logic        e_out_valid;
        logic [11:0] e_pc_4;
        logic [31:0] e_instr;
        logic [11:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    if_id_skid_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc_4   (in_pc_4),
        .in_instr  (in_instr),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc_4  (out_pc_4),
        .out_instr (out_instr),
        .out_addr  (out_addr)
`ifdef IF_ID_SKID_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] g, input logic fl, input logic iv, input logic [11:0] pc,
                       input logic [31:0] ins, input logic [11:0] ad, input logic ordy,
                       input logic eir, input logic eov, input logic [11:0] epc,
                       input logic [31:0] eins, input logic [11:0] ead);
        vec_t v;
        v.go = g; v.flush = fl; v.in_valid = iv; v.pc_4 = pc; v.instr = ins; v.addr = ad;
        v.out_ready = ordy; v.e_in_ready = eir; v.e_out_valid = eov;
        v.e_pc_4 = epc; v.e_instr = eins; v.e_addr = ead;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        go = 2'b11; flush = 1'b0; in_valid = 1'b0;
        in_pc_4 = '0; in_instr = '0; in_addr = '0; out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        drive_idle();

        // Each row: inputs held for one cycle; expected outputs are those seen
        // before the clock edge that consumes the row.
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 0, 1, 0, 12'h000, 32'h0, 12'h000);
        // Streaming pass-through.
        add(2'b11, 0, 1, 12'h004, 32'h1111_0001, 12'h101, 1, 1, 0, 12'h000, 32'h0, 12'h000);
        for (int i = 2; i <= 8; i++) begin
            add(2'b11, 0, 1, 12'(4 * i), 32'h1111_0000 + 32'(i), 12'(12'h100 + i), 1,
                1, 1, 12'(4 * (i - 1)), 32'h1111_0000 + 32'(i - 1), 12'(12'h100 + i - 1));
        end
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 1, 12'h020, 32'h1111_0008, 12'h108);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 0, 12'h000, 32'h0, 12'h000);
        // Backpressure into FULL.
        add(2'b11, 0, 1, 12'h004, 32'hA000_0004, 12'h204, 0, 1, 0, 12'h000, 32'h0, 12'h000);
        add(2'b11, 0, 1, 12'h008, 32'hA000_0008, 12'h208, 0, 1, 1, 12'h004, 32'hA000_0004, 12'h204);
        add(2'b11, 0, 1, 12'h00C, 32'hA000_000C, 12'h20C, 0, 0, 1, 12'h004, 32'hA000_0004, 12'h204);
        // Stall in FULL.
        for (int i = 0; i < 3; i++) begin
            add(2'b01, 0, 1, 12'h00C, 32'hA000_000C, 12'h20C, 1, 0, 0, 12'h004, 32'hA000_0004, 12'h204);
        end
        // Resume and drain in order.
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 0, 1, 12'h004, 32'hA000_0004, 12'h204);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 1, 12'h008, 32'hA000_0008, 12'h208);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 0, 12'h000, 32'h0, 12'h000);
        // Flush from FULL with a same-cycle input.
        add(2'b11, 0, 1, 12'h010, 32'hC000_0010, 12'h310, 0, 1, 0, 12'h000, 32'h0, 12'h000);
        add(2'b11, 0, 1, 12'h014, 32'hC000_0014, 12'h314, 0, 1, 1, 12'h010, 32'hC000_0010, 12'h310);
        add(2'b11, 1, 1, 12'h0EE, 32'hDEAD_BEEF, 12'h0EE, 1, 0, 1, 12'h010, 32'hC000_0010, 12'h310);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 0, 12'h000, 32'h0, 12'h000);
        // Flush wins over go=0.
        add(2'b11, 0, 1, 12'h018, 32'hC000_0018, 12'h318, 0, 1, 0, 12'h000, 32'h0, 12'h000);
        add(2'b00, 1, 1, 12'h01C, 32'hC000_001C, 12'h31C, 1, 0, 0, 12'h018, 32'hC000_0018, 12'h318);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 0, 12'h000, 32'h0, 12'h000);
        // Flush in EMPTY drops the input.
        add(2'b11, 1, 1, 12'h020, 32'hC000_0020, 12'h320, 1, 0, 0, 12'h000, 32'h0, 12'h000);
        add(2'b11, 0, 0, 12'h000, 32'h0, 12'h000, 1, 1, 0, 12'h000, 32'h0, 12'h000);

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.in_ready", 32'(in_ready), 32'h0);
        check("reset.out_instr", out_instr, 32'h0);
        check("reset.out_pc_4", 32'(out_pc_4), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            go = vecs[i].go; flush = vecs[i].flush; in_valid = vecs[i].in_valid;
            in_pc_4 = vecs[i].pc_4; in_instr = vecs[i].instr; in_addr = vecs[i].addr;
            out_ready = vecs[i].out_ready;
            #1;
            check($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_in_ready));
            check($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].e_out_valid));
            check($sformatf("row%0d.out_pc_4", i), 32'(out_pc_4), 32'(vecs[i].e_pc_4));
            check($sformatf("row%0d.out_instr", i), out_instr, vecs[i].e_instr);
            check($sformatf("row%0d.out_addr", i), 32'(out_addr), 32'(vecs[i].e_addr));
            @(posedge clk);
            #1;
        end

        // Async reset while FULL: outputs clear without a clock edge.
        drive_idle();
        in_valid = 1'b1; in_pc_4 = 12'h040; in_instr = 32'hB000_0040; in_addr = 12'h440;
        @(posedge clk); #1;
        in_pc_4 = 12'h044; in_instr = 32'hB000_0044; in_addr = 12'h444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        check("full.in_ready", 32'(in_ready), 32'h0);
        check("full.out_instr", out_instr, 32'hB000_0040);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset.out_valid", 32'(out_valid), 32'h0);
        check("areset.in_ready", 32'(in_ready), 32'h0);
        check("areset.out_instr", out_instr, 32'h0);
        check("areset.out_pc_4", 32'(out_pc_4), 32'h0);
        check("areset.out_addr", 32'(out_addr), 32'h0);
`ifdef IF_ID_SKID_PERF_EN
        check("areset.perf_stall_cnt", 32'(perf_stall_cnt), 32'h0);
        check("areset.perf_flush_cnt", 32'(perf_flush_cnt), 32'h0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_reset.in_ready", 32'(in_ready), 32'h1);
        check("post_reset.out_valid", 32'(out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
